// File: rtl/ldpc_byte_pack.sv
// ---------------------------------------------------------------------------
// ldpc_byte_pack
//   Packs the hard-decision bit stream of an LDPC decoder into bytes. Each
//   9216-bit codeword carries K information bits followed by parity. The
//   information bits are packed MSB-first into bytes, tagged with frame
//   start/end markers, and queued in a small FIFO. Parity bits are dropped.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   code_rate    0: rate 1/2 (K = 4608), 1: rate 3/4 (K = 6912); sampled at bit 0
//   data_in      decoder hard-decision bit, qualified by sync_in
//   sync_in      data_in carries one codeword bit this cycle
//   num_iter     decoder iteration count, sampled at bit 0
//   byte_out     FIFO head byte, first received bit in bit 7
//   byte_valid   FIFO not empty
//   byte_ready   consumer accepts the head entry when byte_valid is high
//   frame_start  head byte is byte 0 of a frame
//   frame_end    head byte is the last information byte of a frame
//   frame_iter   num_iter of the most recently started frame
//   overflow     sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ldpc_byte_pack #(
   parameter int FIFO_DEP = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       code_rate,
   input  logic       data_in,
   input  logic       sync_in,
   input  logic [4:0] num_iter,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       frame_start,
   output logic       frame_end,
   output logic [4:0] frame_iter,
   output logic       overflow
);

   localparam int          AW         = $clog2(FIFO_DEP);
   localparam logic [13:0] LAST_BIT   = 14'd9215;
   localparam logic [13:0] K_LAST_R12 = 14'd4607;
   localparam logic [13:0] K_LAST_R34 = 14'd6911;

   typedef enum logic [1:0] {
      IDLE,
      INFO,
      PARITY
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [13:0]   r_bit_cnt;
   logic [13:0]   w_bit_cnt_nxt;
   logic          r_rate;
   logic [4:0]    r_iter;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;

   logic          w_rate;
   logic [13:0]   w_k_last;
   logic          w_info;
   logic          w_push;
   logic          w_pop;
   logic          w_write;
   logic          w_full;
   logic          w_empty;
   logic [9:0]    w_entry;
   logic [9:0]    w_head;

   logic [9:0]    r_mem [FIFO_DEP];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          r_overflow;

   // -------------------------------------------------------------------------
   // Bit framing
   // -------------------------------------------------------------------------
   // In IDLE the incoming bit is bit 0, so the live code_rate decides K for
   // it; from then on the latched copy keeps K fixed for the whole frame.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_rate        = (r_state == IDLE) ? code_rate : r_rate;
      w_k_last      = w_rate ? K_LAST_R34 : K_LAST_R12;
      w_info        = (r_state != PARITY);
      w_shift_nxt   = {r_shift[6:0], data_in};
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;

      if (sync_in) begin
         w_bit_cnt_nxt = (r_bit_cnt == LAST_BIT) ? 14'd0 : r_bit_cnt + 14'd1;
         unique case (r_state)
            IDLE:    w_state_nxt = INFO;
            INFO:    if (r_bit_cnt == w_k_last) w_state_nxt = PARITY;
            PARITY:  if (r_bit_cnt == LAST_BIT) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // A byte completes on every 8th information bit; K is a multiple of 8, so
   // byte boundaries line up with the counter's low three bits.
   assign w_push  = sync_in && w_info && (r_bit_cnt[2:0] == 3'd7);
   assign w_entry = {(r_bit_cnt[13:3] == 11'd0), (r_bit_cnt == w_k_last), w_shift_nxt};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= 14'd0;
         r_rate    <= 1'b0;
         r_iter    <= 5'd0;
         r_shift   <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         if (sync_in && (r_state == IDLE)) begin
            r_rate <= code_rate;
            r_iter <= num_iter;
         end
         if (sync_in && w_info) begin
            r_shift <= w_shift_nxt;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output FIFO
   // -------------------------------------------------------------------------
   // The extra pointer MSB separates full (MSBs differ) from empty (equal).
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && byte_ready;
   // A pop frees the head slot in the same edge, so a full FIFO still accepts.
   assign w_write = w_push && (!w_full || w_pop);

   // NOTE: the storage array has no reset; the pointers define which entries
   // are live, and the outputs are gated to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_head      = w_empty ? 10'd0 : r_mem[r_rd_ptr[AW-1:0]];
   assign byte_valid  = !w_empty;
   assign byte_out    = w_head[7:0];
   assign frame_end   = w_head[8];
   assign frame_start = w_head[9];
   assign frame_iter  = r_iter;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_ldpc_byte_pack.sv
// ---------------------------------------------------------------------------
// tb_ldpc_byte_pack
//   Directed bench for ldpc_byte_pack. Frames are built from known byte
//   patterns; the expected byte stream (with start/end markers) is derived
//   from the pattern and compared against what a consumer pops.
// ---------------------------------------------------------------------------
module tb_ldpc_byte_pack;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       code_rate;
   logic       data_in;
   logic       sync_in;
   logic [4:0] num_iter;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_start;
   logic       frame_end;
   logic [4:0] frame_iter;
   logic       overflow;

   always #5 clk = ~clk;

   ldpc_byte_pack #(.FIFO_DEP(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .code_rate   (code_rate),
      .data_in     (data_in),
      .sync_in     (sync_in),
      .num_iter    (num_iter),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .frame_iter  (frame_iter),
      .overflow    (overflow)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [9:0] got_q [$];
   logic [9:0] exp_q [$];

   // Current frame description used by the stimulus tasks.
   logic       cur_rate;
   int         cur_mode;
   logic [4:0] cur_iter;
   bit         cur_toggle;
   bit         gaps;

   // Consumer: inputs change 1 ns after the rising edge, so the values seen
   // on the falling edge are the ones the next rising edge acts on.
   always @(negedge clk) begin
      if (reset_n && byte_valid && byte_ready)
         got_q.push_back({frame_start, frame_end, byte_out});
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int mode, input int i);
      if (mode == 0) return 8'hA5;
      return 8'(i * (2 * mode + 27) + (i >> 3) + mode * 61);
   endfunction

   function automatic int k_bits(input logic rate);
      return rate ? 6912 : 4608;
   endfunction

   // Sends frame bits [from, to); each call returns 1 ns after the edge that
   // sampled the last bit.
   task automatic send_bits(input int from, input int to);
      logic [7:0] pb;
      for (int b = from; b < to; b++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               sync_in = 1'b0;
               data_in = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
         if (b == 0 || !cur_toggle) begin
            code_rate = cur_rate;
            num_iter  = cur_iter;
         end else begin
            code_rate = ~cur_rate;
            num_iter  = cur_iter ^ 5'h0A;
         end
         pb      = pat(cur_mode, b / 8);
         sync_in = 1'b1;
         data_in = (b < k_bits(cur_rate)) ? pb[7 - (b % 8)] : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         sync_in = 1'b0;
      end
   endtask

   task automatic expect_bytes(input int first, input int last);
      int nb;
      nb = k_bits(cur_rate) / 8;
      for (int i = first; i <= last; i++)
         exp_q.push_back({(i == 0), (i == nb - 1), pat(cur_mode, i)});
   endtask

   task automatic drain(input int n);
      int c;
      c = 0;
      while (c < 3000 && (got_q.size() < n || byte_valid)) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic compare(input string tag);
      int nbad;
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n    = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      nbad = 0;
      for (int i = 0; i < n; i++)
         if (got_q[i] !== exp_q[i]) nbad++;
      check({tag, "_bad_bytes"}, nbad, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse_reset();
      sync_in = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      code_rate  = 1'b0;
      data_in    = 1'b0;
      sync_in    = 1'b0;
      num_iter   = 5'd0;
      byte_ready = 1'b0;
      cur_toggle = 1'b0;
      gaps       = 1'b0;

      // Reset state
      #12;
      check("rst_valid", byte_valid, 0);
      check("rst_byte", byte_out, 0);
      check("rst_start", frame_start, 0);
      check("rst_end", frame_end, 0);
      check("rst_iter", frame_iter, 0);
      check("rst_ovf", overflow, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Rate 1/2, contiguous, 0xA5 pattern
      byte_ready = 1'b1;
      cur_rate = 1'b0; cur_mode = 0; cur_iter = 5'd3;
      send_bits(0, 9216);
      expect_bytes(0, 575);
      drain(576);
      compare("r12");
      check("r12_iter", frame_iter, 3);
      check("r12_ovf", overflow, 0);

      // Rate 3/4 with gaps; code_rate/num_iter disturbed after bit 0
      gaps = 1'b1; cur_toggle = 1'b1;
      cur_rate = 1'b1; cur_mode = 1; cur_iter = 5'd7;
      send_bits(0, 100);
      check("r34_iter_mid", frame_iter, 7);
      send_bits(100, 9216);
      expect_bytes(0, 863);
      drain(864);
      compare("r34_gap");
      check("r34_iter", frame_iter, 7);
      gaps = 1'b0; cur_toggle = 1'b0;

      // Overflow: consumer stalled for a whole frame
      pulse_reset();
      byte_ready = 1'b0;
      cur_rate = 1'b0; cur_mode = 2; cur_iter = 5'd4;
      send_bits(0, 128);
      check("ovf_16_clear", overflow, 0);
      check("ovf_16_valid", byte_valid, 1);
      send_bits(128, 136);
      check("ovf_17_set", overflow, 1);
      send_bits(136, 9216);
      check("ovf_head_byte", byte_out, pat(2, 0));
      check("ovf_head_start", frame_start, 1);
      byte_ready = 1'b1;
      expect_bytes(0, 15);
      drain(16);
      compare("ovf_keep");
      check("ovf_sticky", overflow, 1);

      // Full FIFO with push and pop on the same edge
      pulse_reset();
      byte_ready = 1'b0;
      cur_rate = 1'b0; cur_mode = 3; cur_iter = 5'd5;
      send_bits(0, 135);
      check("pp_pre_ovf", overflow, 0);
      byte_ready = 1'b1;
      send_bits(135, 136);
      byte_ready = 1'b0;
      check("pp_ovf", overflow, 0);
      check("pp_valid", byte_valid, 1);
      byte_ready = 1'b1;
      expect_bytes(0, 16);
      drain(17);
      compare("full_pp");
      check("pp_ovf_end", overflow, 0);
      pulse_reset();

      // Back-to-back frames: rate 1/2 (rate toggled mid-frame) then rate 3/4
      cur_rate = 1'b0; cur_mode = 4; cur_iter = 5'd9; cur_toggle = 1'b1;
      send_bits(0, 9216);
      expect_bytes(0, 575);
      check("b2b_iter_a", frame_iter, 9);
      cur_rate = 1'b1; cur_mode = 5; cur_iter = 5'd21; cur_toggle = 1'b0;
      send_bits(0, 9216);
      expect_bytes(0, 863);
      drain(1440);
      compare("b2b");
      check("b2b_iter_b", frame_iter, 21);

      // Reset in the middle of a frame
      byte_ready = 1'b0;
      cur_rate = 1'b0; cur_mode = 6; cur_iter = 5'd11;
      send_bits(0, 3000);
      check("mid_pre_ovf", overflow, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", byte_valid, 0);
      check("mid_rst_byte", byte_out, 0);
      check("mid_rst_start", frame_start, 0);
      check("mid_rst_end", frame_end, 0);
      check("mid_rst_iter", frame_iter, 0);
      check("mid_rst_ovf", overflow, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      got_q.delete();
      byte_ready = 1'b1;
      cur_rate = 1'b1; cur_mode = 7; cur_iter = 5'd2;
      send_bits(0, 9216);
      expect_bytes(0, 863);
      drain(864);
      compare("post_rst");
      check("post_rst_iter", frame_iter, 2);
      check("post_rst_ovf", overflow, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ldpc_byte_pack.md
LDPC_BYTE_PACK -- requirements
Module: ldpc_byte_pack

Interface
REQ-001 Parameter FIFO_DEP, default 16, output FIFO depth in bytes, power of two, 4..64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 code_rate  input  1  0 = rate 1/2, K = 4608 info bits; 1 = rate 3/4, K = 6912 info bits.
REQ-005 data_in  input  1  hard-decision bit from the LDPC decoder, qualified by sync_in.
REQ-006 sync_in  input  1  high = data_in carries one valid codeword bit this cycle.
REQ-007 num_iter  input  5  decoder iteration count for the current frame.
REQ-008 byte_out  output  8  head byte of the FIFO; first received bit in bit 7.
REQ-009 byte_valid  output  1  FIFO not empty; byte_out, frame_start and frame_end are valid.
REQ-010 byte_ready  input  1  consumer accepts the head entry when byte_valid & byte_ready.
REQ-011 frame_start  output  1  head byte is the first info byte of a frame.
REQ-012 frame_end  output  1  head byte is the last info byte of a frame.
REQ-013 frame_iter  output  5  num_iter captured for the most recently started frame.
REQ-014 overflow  output  1  sticky flag: at least one byte was dropped.

Function
REQ-015 A frame SHALL be 9216 qualified bits: the first K are information bits, and bits K..9215 are parity and SHALL be discarded.
REQ-016 Qualified bits SHALL be counted by a 14-bit bit counter; cycles with sync_in low SHALL hold all state, so gaps inside a frame are legal.
REQ-017 The FSM SHALL have the states IDLE, INFO and PARITY.
REQ-018 IDLE: on sync_in high, code_rate and num_iter SHALL be latched (K fixed for the whole frame), the bit SHALL be packed, and the FSM SHALL go to INFO.
REQ-019 INFO: the FSM SHALL go to PARITY on the edge that samples info bit K-1 (counter = K-1).
REQ-020 PARITY: the FSM SHALL go to IDLE on the edge that samples bit 9215, with the counter wrapping to 0.
REQ-021 Bits SHALL be shifted into an 8-bit register MSB-first; the byte SHALL be written to the FIFO on the same edge that samples its 8th bit.
REQ-022 Each frame SHALL produce K/8 bytes: 576 at rate 1/2 and 864 at rate 3/4.
REQ-023 Each FIFO entry SHALL be 10 bits: the byte, frame_start (byte index 0) and frame_end (byte index K/8-1).
REQ-024 byte_valid SHALL rise the cycle after a write into an empty FIFO (1-cycle latency).
REQ-025 A pop SHALL occur only on byte_valid & byte_ready; byte_out SHALL hold stable while byte_valid is high and byte_ready is low.
REQ-026 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; occupancy SHALL be unchanged.
REQ-027 A push to a full FIFO with no simultaneous pop SHALL drop the byte, set overflow, and leave FIFO contents and pointers unchanged.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEP, with an extra pointer bit to distinguish full from empty.
REQ-029 frame_iter SHALL update on the edge that samples bit 0 of a frame and hold until the next frame starts.
REQ-030 Changes on code_rate or num_iter after bit 0 SHALL have no effect until the next frame.
REQ-031 A new frame SHALL start back-to-back: sync_in high in the cycle after bit 9215 is bit 0 of the next frame.

Reset
REQ-032 While reset_n is low: FSM = IDLE, bit counter = 0, shift register = 0, FIFO empty, byte_valid = 0, byte_out = 0, frame_start = 0, frame_end = 0, frame_iter = 0, overflow = 0.
REQ-033 Assertion of reset_n mid-frame SHALL discard the partial frame and all FIFO contents immediately (asynchronously); the first qualified bit after release SHALL be bit 0.

Verification
REQ-034 Rate 1/2, 9216 contiguous bits, info pattern 0xA5 repeated, byte_ready = 1 -> 576 bytes of 0xA5; frame_start on byte 0, frame_end on byte 575; overflow = 0.
REQ-035 Rate 3/4, num_iter = 7, random gaps in sync_in -> exactly 864 bytes matching the info bits, frame_iter = 7, no parity byte emitted.
REQ-036 byte_ready = 0 throughout a frame, FIFO_DEP = 16 -> 16 bytes held, overflow set at the 17th byte, first 16 bytes intact when byte_ready is later raised.
REQ-037 FIFO full, with push and pop in the same cycle -> occupancy stays 16, overflow stays 0, bytes in order.
REQ-038 Two back-to-back frames, rate 1/2 then rate 3/4 (code_rate toggled during frame 1) -> 576 then 864 bytes, correct frame_start/frame_end markers.
REQ-039 reset_n pulsed low at bit 3000 of a frame -> outputs reach reset values; a following full frame yields exactly K/8 correct bytes.
